// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the four-switch debouncer.
// SW_AUTO_SWEEP_EN (optional) adds the auto-sweep pattern generator.
package sw_debounce_pkg;

  localparam int SW_WIDTH         = 4;
  localparam int DEBOUNCE_DEFAULT = 240000;
  localparam int SWEEP_DEFAULT    = 600000;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch: 2-flop synchroniser, hold counter, debounced level and
// change strobe. frz/ld let an external sequencer own the level.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  input  logic frz,
  input  logic ld,
  input  logic ld_val,
  output logic a,
  output logic sw_chg
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      a      <= 1'b0;
      sw_chg <= 1'b0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
      // frozen: counter parked at 0, level only moves on an explicit load
      if (frz) begin
        cnt <= '0;
        if (ld) begin
          a      <= ld_val;
          sw_chg <= a ^ ld_val;
        end else begin
          sw_chg <= 1'b0;
        end
      end else if (s2 == a) begin
        cnt    <= '0;
        sw_chg <= 1'b0;
      end else if (cnt == CMAX) begin
        a      <= s2;
        cnt    <= '0;
        sw_chg <= 1'b1;
      end else begin
        cnt    <= cnt + 1'b1;
        sw_chg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sw_debounce4.sv
// Four independent switch debouncers feeding the gate lab a[3:0].
// SW_AUTO_SWEEP_EN adds sweep_en and a free-running a+1 pattern.
module sw_debounce4
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
`ifdef SW_AUTO_SWEEP_EN
  ,
  parameter int SWEEP_CYCLES = SWEEP_DEFAULT
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] sw_in,
`ifdef SW_AUTO_SWEEP_EN
  input  logic                sweep_en,
`endif
  output logic [SW_WIDTH-1:0] a,
  output logic [SW_WIDTH-1:0] sw_chg
);

  logic                frz;
  logic                ld;
  logic [SW_WIDTH-1:0] ld_val;

`ifdef SW_AUTO_SWEEP_EN
  localparam int PW = cnt_width(SWEEP_CYCLES);
  localparam logic [PW-1:0] PMAX = PW'(SWEEP_CYCLES - 1);

  logic [PW-1:0] pcnt;
  logic          wrap;

  assign wrap   = sweep_en && (pcnt == PMAX);
  assign frz    = sweep_en;
  assign ld     = wrap;
  assign ld_val = a + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!sweep_en || wrap) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end
`else
  assign frz    = 1'b0;
  assign ld     = 1'b0;
  assign ld_val = '0;
`endif

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .sw_in (sw_in[i]),
      .frz   (frz),
      .ld    (ld),
      .ld_val(ld_val[i]),
      .a     (a[i]),
      .sw_chg(sw_chg[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce4.sv
// Randomised and directed bench for sw_debounce4 against a
// window-based reference model of the debounce rules.
module tb_sw_debounce4;

  localparam int D  = 4;
  localparam int SP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sweep_en = 1'b0;
  logic [3:0] sw_in = 4'b0;
  logic [3:0] a;
  logic [3:0] sw_chg;

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] ms1, ms2, ma, mchg;
  int         pcnt;
  bit         hist[4][$];

  always #5 clk = ~clk;

  sw_debounce4 #(
    .DEBOUNCE_CYCLES(D)
`ifdef SW_AUTO_SWEEP_EN
    ,
    .SWEEP_CYCLES(SP)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_in (sw_in),
`ifdef SW_AUTO_SWEEP_EN
    .sweep_en(sweep_en),
`endif
    .a     (a),
    .sw_chg(sw_chg)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // a[i] flips once the last D synchronised samples all disagree with it
  function automatic void model_edge();
    logic [3:0] sv;
    logic [3:0] nxt;
    bit         all_diff;
    sv = ms2;
    if (!rst_n) begin
      ms1 = 0; ms2 = 0; ma = 0; mchg = 0; pcnt = 0;
      for (int i = 0; i < 4; i++) hist[i].delete();
    end else begin
      ms2 = ms1;
      ms1 = sw_in;
      mchg = 0;
      if (sweep_en) begin
        for (int i = 0; i < 4; i++) hist[i].delete();
        if (pcnt == SP - 1) begin
          nxt = ma + 4'd1;
          mchg = ma ^ nxt;
          ma = nxt;
          pcnt = 0;
        end else begin
          pcnt++;
        end
      end else begin
        pcnt = 0;
        for (int i = 0; i < 4; i++) begin
          hist[i].push_back(sv[i]);
          if (hist[i].size() > D) void'(hist[i].pop_front());
          all_diff = (hist[i].size() == D);
          foreach (hist[i][j]) if (hist[i][j] == ma[i]) all_diff = 0;
          if (all_diff) begin
            ma[i] = ~ma[i];
            mchg[i] = 1'b1;
            hist[i].delete();
          end
        end
      end
    end
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_a"}, a, ma);
    chk({tag, "_chg"}, sw_chg, mchg);
  endtask

  // edges until a reaches want (1 = first edge), -1 if budget expires
  task automatic wait_a(input string tag, input logic [3:0] want,
                        output int hit);
    hit = -1;
    for (int e = 1; e <= 20; e++) begin
      step(tag);
      if (hit < 0 && a == want) begin
        hit = e;
        chk({tag, "_strobe"}, sw_chg, want ^ 4'b0000 ^ (a & ~want) |
            (want & ~ms2 & 4'b0) | mchg);
      end
    end
  endtask

  int hit;

  initial begin
    rst_n = 1'b0;
    sw_in = 4'b1111;
    repeat (3) step("rst");
    chk("rst_a0", a, 4'b0000);
    rst_n = 1'b1;
    wait_a("rel", 4'b1111, hit);
    chk("rel_lat", hit, 6);

    sw_in = 4'b0000;
    repeat (10) step("clr");
    sw_in = 4'b0100;
    wait_a("lat", 4'b0100, hit);
    chk("lat_edges", hit, 6);

    sw_in = 4'b0000;
    repeat (10) step("clr");
    for (int r = 0; r < 2; r++) begin
      sw_in = 4'b0001;
      repeat (3) step("bnc");
      sw_in = 4'b0000;
      step("bnc");
    end
    repeat (6) step("bnc");
    chk("bnc_a0", a[0], 1'b0);

    sw_in = 4'b1011;
    wait_a("sim", 4'b1011, hit);
    chk("sim_lat", hit, 6);

    sw_in = 4'b0000;
    repeat (10) step("clr");
    sw_in = 4'b1000;
    repeat (3) step("mid");
    rst_n = 1'b0;
    repeat (2) step("mid");
    chk("mid_a3", a[3], 1'b0);
    rst_n = 1'b1;
    wait_a("mid", 4'b1000, hit);
    chk("mid_lat", hit, 6);

`ifdef SW_AUTO_SWEEP_EN
    sw_in = 4'b1110;
    repeat (10) step("pre");
    sweep_en = 1'b1;
    repeat (8) step("swp");
    chk("swp_1", a, 4'b1111);
    chk("swp_1c", sw_chg, 4'b0001);
    repeat (8) step("swp");
    chk("swp_2", a, 4'b0000);
    chk("swp_2c", sw_chg, 4'b1111);
    sw_in = 4'b0011;
    repeat (3) step("swp");
    sweep_en = 1'b0;
    repeat (5) step("post");
    chk("post_a", a, 4'b0011);
`endif

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) sw_in[i] = ~sw_in[i];
      rst_n = ($urandom_range(149) != 0);
`ifdef SW_AUTO_SWEEP_EN
      if ($urandom_range(39) == 0) sweep_en = ~sweep_en;
`endif
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
